// File: rtl/plic_irq_gateway_if.sv
// Signal bundle between the interrupt sources / register file and the PLIC gateway.
interface plic_irq_gateway_if #(
    parameter int NUM_IRQ = 1024
);
    logic               test_mode_i;
    logic [NUM_IRQ-1:0] irq_src_i;
    logic [NUM_IRQ-1:0] irq_edge_cfg_i;
    logic [NUM_IRQ-1:0] irq_mask_i;
    logic [NUM_IRQ-1:0] int_pending_o;
    logic [NUM_IRQ-1:0] irq_held_o;

    modport master (
        output test_mode_i,
        output irq_src_i,
        output irq_edge_cfg_i,
        output irq_mask_i,
        input  int_pending_o,
        input  irq_held_o
    );

    modport slave (
        input  test_mode_i,
        input  irq_src_i,
        input  irq_edge_cfg_i,
        input  irq_mask_i,
        output int_pending_o,
        output irq_held_o
    );
endinterface

// File: rtl/plic_irq_gateway.sv
// PLIC interrupt gateway: synchronises raw sources, applies level/edge semantics and
// tracks claim/complete per source to produce the registered pending vector.
module plic_irq_gateway #(
    parameter int NUM_IRQ     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    plic_irq_gateway_if.slave   gw
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PEND    = 2'b01,
        ST_CLAIMED = 2'b10,
        ST_HELD    = 2'b11
    } state_t;

    logic [NUM_IRQ-1:0] sync_r [SYNC_STAGES];
    logic [NUM_IRQ-1:0] s_s;
    logic [NUM_IRQ-1:0] s_d_r;
    logic [NUM_IRQ-1:0] ev_s;
    logic [NUM_IRQ-1:0] pend_nx_s;
    logic [NUM_IRQ-1:0] held_nx_s;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] held_r;

    // Synchroniser chain for the raw asynchronous sources
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= gw.irq_src_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Synchronised level: test mode taps the first capture flop only
    always_comb begin
        s_s = sync_r[SYNC_STAGES-1];
        if (gw.test_mode_i) begin
            s_s = sync_r[0];
        end else begin
            s_s = sync_r[SYNC_STAGES-1];
        end
    end

    // Event: rising edge in edge mode, the level itself in level mode
    always_comb begin
        ev_s = (gw.irq_edge_cfg_i & s_s & ~s_d_r) | (~gw.irq_edge_cfg_i & s_s);
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
        state_t state_r;
        state_t state_nx_s;
        logic   mask_s;
        logic   edge_s;

        assign mask_s = gw.irq_mask_i[g];
        assign edge_s = gw.irq_edge_cfg_i[g];

        // Per-source claim tracking; source 0 is reserved and pinned to IDLE
        always_comb begin
            state_nx_s = state_r;
            if (g == 32'sd0) begin
                state_nx_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (mask_s && ev_s[g]) begin
                            state_nx_s = ST_PEND;
                        end else if (!mask_s && edge_s && ev_s[g]) begin
                            state_nx_s = ST_HELD;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end
                    ST_PEND: begin
                        if (!mask_s && edge_s && ev_s[g]) begin
                            state_nx_s = ST_HELD;
                        end else if (!mask_s) begin
                            state_nx_s = ST_CLAIMED;
                        end else begin
                            state_nx_s = ST_PEND;
                        end
                    end
                    ST_CLAIMED: begin
                        if (edge_s && ev_s[g]) begin
                            state_nx_s = ST_HELD;
                        end else if (mask_s && ev_s[g]) begin
                            state_nx_s = ST_PEND;
                        end else if (mask_s) begin
                            state_nx_s = ST_IDLE;
                        end else begin
                            state_nx_s = ST_CLAIMED;
                        end
                    end
                    ST_HELD: begin
                        if (mask_s) begin
                            state_nx_s = ST_PEND;
                        end else begin
                            state_nx_s = ST_HELD;
                        end
                    end
                    default: begin
                        state_nx_s = ST_IDLE;
                    end
                endcase
            end
        end

        // Per-source state register
        always_ff @(posedge pclk_i) begin
            if (prst_i) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_nx_s;
            end
        end

        assign pend_nx_s[g] = (state_nx_s == ST_PEND);
        assign held_nx_s[g] = (state_nx_s == ST_HELD);
    end

    // Edge history and output flops, kept in lock-step with the state flops
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            s_d_r     <= '0;
            pending_r <= '0;
            held_r    <= '0;
        end else begin
            s_d_r     <= s_s;
            pending_r <= pend_nx_s;
            held_r    <= held_nx_s;
        end
    end

    assign gw.int_pending_o = pending_r;
    assign gw.irq_held_o    = held_r;
endmodule

// File: tb/tb_plic_irq_gateway.sv
// Directed self-checking bench for plic_irq_gateway with NUM_IRQ=8, SYNC_STAGES=2.
module tb_plic_irq_gateway;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    plic_irq_gateway_if #(.NUM_IRQ(N)) gw ();

    plic_irq_gateway #(.NUM_IRQ(N), .SYNC_STAGES(2)) dut (
        .pclk_i (clk),
        .prst_i (rst),
        .gw     (gw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [N-1:0] pend, input logic [N-1:0] held);
        chk({tag, ".pending"}, gw.int_pending_o, pend);
        chk({tag, ".held"}, gw.irq_held_o, held);
    endtask

    task automatic pulse5();
        gw.irq_src_i[5] = 1'b1;
        tick(3);
        gw.irq_src_i[5] = 1'b0;
        tick(3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        gw.test_mode_i    = 1'b0;
        gw.irq_src_i      = 8'h00;
        gw.irq_edge_cfg_i = 8'h00;
        gw.irq_mask_i     = 8'hFF;
        tick(1);
        chk_both("reset", 8'h00, 8'h00);
        rst = 1'b0;
        tick(1);

        // Level source 3
        gw.irq_src_i[3] = 1'b1;
        tick(2);
        chk_both("lvl_not_early", 8'h00, 8'h00);
        tick(1);
        chk_both("lvl_pend", 8'h08, 8'h00);
        gw.irq_mask_i[3] = 1'b0;
        tick(1);
        chk_both("lvl_claim", 8'h00, 8'h00);
        gw.irq_mask_i[3] = 1'b1;
        tick(1);
        chk_both("lvl_repend", 8'h08, 8'h00);
        gw.irq_src_i[3] = 1'b0;
        tick(3);
        chk_both("lvl_sticky", 8'h08, 8'h00);
        gw.irq_mask_i[3] = 1'b0;
        tick(1);
        chk_both("lvl_claim2", 8'h00, 8'h00);
        gw.irq_mask_i[3] = 1'b1;
        tick(1);
        chk_both("lvl_complete_low", 8'h00, 8'h00);
        tick(1);
        chk_both("lvl_idle", 8'h00, 8'h00);

        // Edge source 5
        gw.irq_edge_cfg_i[5] = 1'b1;
        gw.irq_src_i[5] = 1'b1;
        tick(3);
        chk_both("edge_pend", 8'h20, 8'h00);
        gw.irq_src_i[5] = 1'b0;
        tick(3);
        chk_both("edge_single", 8'h20, 8'h00);
        gw.irq_mask_i[5] = 1'b0;
        tick(1);
        chk_both("edge_claim", 8'h00, 8'h00);
        gw.irq_src_i[5] = 1'b1;
        tick(3);
        chk_both("edge_held", 8'h00, 8'h20);
        gw.irq_src_i[5] = 1'b0;
        tick(3);
        chk_both("edge_held_stay", 8'h00, 8'h20);
        gw.irq_mask_i[5] = 1'b1;
        tick(1);
        chk_both("edge_release", 8'h20, 8'h00);
        gw.irq_mask_i[5] = 1'b0;
        tick(1);
        chk_both("edge_claim2", 8'h00, 8'h00);
        pulse5();
        pulse5();
        chk_both("edge_two_held", 8'h00, 8'h20);
        gw.irq_mask_i[5] = 1'b1;
        tick(1);
        chk_both("edge_two_release", 8'h20, 8'h00);
        gw.irq_mask_i[5] = 1'b0;
        tick(1);
        chk_both("edge_two_claim", 8'h00, 8'h00);
        gw.irq_mask_i[5] = 1'b1;
        tick(1);
        chk_both("edge_no_count", 8'h00, 8'h00);

        // Claim and new edge in the same cycle on source 2
        gw.irq_edge_cfg_i[2] = 1'b1;
        gw.irq_src_i[2] = 1'b1;
        tick(3);
        chk_both("sim_pend", 8'h04, 8'h00);
        gw.irq_src_i[2] = 1'b0;
        tick(3);
        gw.irq_src_i[2] = 1'b1;
        tick(2);
        gw.irq_mask_i[2] = 1'b0;
        tick(1);
        chk_both("sim_held", 8'h00, 8'h04);
        gw.irq_src_i[2] = 1'b0;
        tick(3);
        gw.irq_mask_i[2] = 1'b1;
        tick(1);
        chk_both("sim_release", 8'h04, 8'h00);
        gw.irq_mask_i[2] = 1'b0;
        tick(1);
        gw.irq_mask_i[2] = 1'b1;
        tick(1);
        chk_both("sim_idle", 8'h00, 8'h00);

        // Reserved source 0 in both modes
        gw.irq_src_i[0] = 1'b1;
        gw.irq_edge_cfg_i[0] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            chk_both("src0_level", 8'h00, 8'h00);
        end
        gw.irq_edge_cfg_i[0] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            gw.irq_mask_i[0] = i[0];
            tick(1);
            chk_both("src0_edge", 8'h00, 8'h00);
        end
        gw.irq_src_i[0]  = 1'b0;
        gw.irq_mask_i[0] = 1'b1;
        tick(3);

        // Test mode: single capture flop
        gw.test_mode_i = 1'b1;
        gw.irq_src_i[1] = 1'b1;
        tick(1);
        chk_both("tm_not_early", 8'h00, 8'h00);
        tick(1);
        chk_both("tm_pend", 8'h02, 8'h00);
        gw.irq_src_i[1] = 1'b0;
        tick(1);
        gw.irq_mask_i[1] = 1'b0;
        tick(1);
        chk_both("tm_claim", 8'h00, 8'h00);
        gw.irq_mask_i[1] = 1'b1;
        tick(1);
        chk_both("tm_idle", 8'h00, 8'h00);
        gw.test_mode_i = 1'b0;
        tick(3);

        // Reset mid-operation
        gw.irq_edge_cfg_i[6] = 1'b1;
        gw.irq_mask_i[6] = 1'b0;
        gw.irq_src_i = 8'h52;
        tick(3);
        chk_both("rst_pre", 8'h12, 8'h40);
        gw.irq_src_i = 8'h02;
        rst = 1'b1;
        tick(1);
        chk_both("rst_mid", 8'h00, 8'h00);
        rst = 1'b0;
        gw.irq_mask_i = 8'hFF;
        tick(2);
        chk_both("rst_not_early", 8'h00, 8'h00);
        tick(1);
        chk_both("rst_repend", 8'h02, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/plic_irq_gateway.md
Name: plic_irq_gateway

Overview:
- Interrupt gateway stage directly upstream of the PLIC register file.
- Synchronises raw asynchronous interrupt sources into pclk_i and applies level or edge semantics per source.
- Produces the int_pending vector consumed by the register file and the arbiters.
- Honours the register file's irq_mask: mask low means claimed-not-completed; it clears pending and blocks re-pend until completion. For edge sources, one edge arriving during a claim is remembered.

Parameters:
- NUM_IRQ, 1024, number of interrupt sources; index 0 is reserved and never pends.
- SYNC_STAGES, 2, synchroniser depth, legal range 2..4.

Ports:
- pclk_i  input  1  gateway clock, same clock as the register file.
- prst_i  input  1  reset, synchronous, active-high.
- test_mode_i  input  1  when 1, bypasses the synchroniser chain (single capture flop only).
- irq_src_i  input  NUM_IRQ  raw asynchronous interrupt sources, active-high.
- irq_edge_cfg_i  input  NUM_IRQ  per-source mode: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- irq_mask_i  input  NUM_IRQ  from the register file irq_mask_o: 0 = claimed/in service, 1 = completed/open.
- int_pending_o  output  NUM_IRQ  registered pending vector to the register file and arbiters.
- irq_held_o  output  NUM_IRQ  per-source flag: an edge was captured during a claim (debug/observability).

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the pclk_i rising edge.
- Reset clears all synchroniser flops, all edge-history flops, and all state (IDLE). int_pending_o = 0 and irq_held_o = 0 from the first edge with prst_i high.

Synchroniser:
- test_mode_i = 0: s[i] is irq_src_i[i] after SYNC_STAGES flops.
- test_mode_i = 1: s[i] is irq_src_i[i] after one flop.
- s_d[i] is s[i] delayed one cycle; it resets to 0, so a source already high at reset release counts as one rising edge.

Event:
- ev[i] = irq_edge_cfg_i[i] ? (s[i] & ~s_d[i]) : s[i].
- irq_edge_cfg_i changes take effect on the next event evaluation; state is not reset by a mode change.

Per-source FSM, 2 bits. States IDLE, PEND, CLAIMED, HELD. Transitions are evaluated in the order listed:
- IDLE:
  - mask=1 & ev -> PEND.
  - mask=0 & edge mode & ev -> HELD.
  - else stay.
- PEND:
  - mask=0 & edge mode & ev -> HELD (claim and new edge in the same cycle; the edge is kept).
  - mask=0 -> CLAIMED.
  - else stay. Level sources stay pending even if the level drops before the claim.
- CLAIMED:
  - edge mode & ev -> HELD.
  - mask=1 & ev (level high at completion) -> PEND.
  - mask=1 -> IDLE.
  - else stay.
- HELD:
  - mask=1 -> PEND.
  - else stay. Further edges are merged; there is no counting.
  - A source switched to level mode while in HELD still goes to PEND on mask=1.

Outputs and timing:
- int_pending_o[i] = (state==PEND); decoded from the state flops, no combinational path from inputs.
- irq_held_o[i] = (state==HELD).
- Source 0: state is forced to IDLE every cycle; int_pending_o[0] = 0 and irq_held_o[0] = 0 always.
- Latency, source rise to int_pending_o high: SYNC_STAGES+1 pclk_i edges (2 edges when test_mode_i=1).
- Latency, mask falling to int_pending_o low: 1 edge.
- Latency, mask rising to re-pend: 1 edge.
- Reset asserted mid-operation: all state drops to IDLE on that edge; events in flight are discarded.

Test Plan:
- Level, NUM_IRQ=8, SYNC_STAGES=2: raise irq_src_i[3] at cycle 10 with mask=all-ones -> int_pending_o[3]=1 from cycle 13. Drive mask[3]=0 at 20 -> pending[3]=0 at 21. Mask[3]=1 at 30 with source still high -> pending[3]=1 at 31.
- Edge, src 5, cfg[5]=1: pulse high 3 cycles -> single pending. Claim (mask[5]=0), second pulse during claim -> irq_held_o[5]=1. Release mask -> pending[5]=1 the next cycle and held=0. Two pulses during one claim -> still one pending.
- Simultaneous: src 2 in PEND; drive mask[2]=0 in the same cycle the synchronised edge arrives -> state HELD, pending[2]=0, held[2]=1. Mask=1 -> pending[2]=1.
- Source 0 driven high in both modes for 50 cycles -> int_pending_o[0]=0 and irq_held_o[0]=0 throughout.
- test_mode_i=1: source 1 rises at cycle 10 -> pending[1]=1 at cycle 12.
- Reset mid-operation: sources 1, 4 pending and 6 held; assert prst_i one cycle -> all outputs 0 next edge. With level source 1 still high after release -> pending[1] re-asserts SYNC_STAGES+1 edges after reset deasserts.
